// File: rtl/mmu_pkg.sv
// Shared definitions for the 68k-style MMU TLB: controller states, function-code
// and PTE field positions, and default geometry.
package mmu_pkg;

    localparam int VPN_W_DEF  = 12;
    localparam int PPN_W_DEF  = 16;
    localparam int TASK_W_DEF = 4;
    localparam int DEPTH_DEF  = 4;

    localparam int FC_SUP_BIT  = 2;
    localparam int PTE_PPN_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } tlb_state_e;

    // The present flag sits directly above the PPN field.
    function automatic int pte_present_bit(input int ppn_w);
        return PTE_PPN_LSB + ppn_w;
    endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully associative tag/PPN store with single-cycle parallel match,
// one write port and a flush-all that clears every valid bit.
module mmu_tlb_cam
    import mmu_pkg::*;
#(
    parameter int TAG_W = TASK_W_DEF + VPN_W_DEF,
    parameter int PPN_W = PPN_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic [PPN_W-1:0] hit_ppn,
    output logic [DEPTH-1:0] valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PPN_W-1:0] wr_ppn,
    input  logic             flush_all
);

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PPN_W-1:0] ppn_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (tag_mem[gi] == lookup_tag);
        end
    endgenerate

    // Lowest matching index wins; only one entry should ever match.
    always_comb begin
        hit_idx = '0;
        hit_ppn = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = IDX_W'(i);
                hit_ppn = ppn_mem[i];
            end
        end
    end

    assign hit   = |match;
    assign valid = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (flush_all) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            ppn_mem[wr_idx] <= wr_ppn;
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// Translation controller: supervisor bypass, TLB lookup, page-table fetch on miss,
// victim selection (lowest free, else round-robin) and a held response handshake.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int VPN_W  = VPN_W_DEF,
    parameter int PPN_W  = PPN_W_DEF,
    parameter int TASK_W = TASK_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [VPN_W-1:0]        req_vpn,
    input  logic [2:0]              req_fc,
    input  logic [TASK_W-1:0]       req_task,
    input  logic [PPN_W-VPN_W-1:0]  sup_base,
    input  logic                    flush,
    output logic                    tbl_req,
    output logic [TASK_W+VPN_W-1:0] tbl_addr,
    input  logic                    tbl_ack,
    input  logic [PPN_W:0]          tbl_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [PPN_W-1:0]        resp_ppn,
    output logic                    resp_fault,
    output logic [15:0]             hit_count
);

    localparam int IDX_W       = $clog2(DEPTH);
    localparam int TAG_W       = TASK_W + VPN_W;
    localparam int PRESENT_BIT = pte_present_bit(PPN_W);

    tlb_state_e       state_reg, state_next;
    logic             alive_reg;
    logic [TAG_W-1:0] tbl_addr_reg;
    logic [PPN_W-1:0] resp_ppn_reg;
    logic             resp_fault_reg;
    logic             flush_seen_reg;
    logic [IDX_W-1:0] rr_reg;
    logic [15:0]      hit_count_reg;

    logic             accept;
    logic             is_sup;
    logic [TAG_W-1:0] lookup_tag;
    logic             cam_hit;
    logic [IDX_W-1:0] cam_hit_idx_unused;
    logic [PPN_W-1:0] cam_hit_ppn;
    logic [DEPTH-1:0] cam_valid;
    logic             ack_fetch;
    logic             pte_present;
    logic             install;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim_idx;

    // alive_reg keeps req_ready low until the first edge after reset release.
    assign req_ready   = alive_reg && (state_reg == IDLE);
    assign accept      = req_valid && req_ready;
    assign is_sup      = req_fc[FC_SUP_BIT];
    assign lookup_tag  = {req_task, req_vpn};
    assign ack_fetch   = (state_reg == FETCH) && tbl_ack;
    assign pte_present = tbl_data[PRESENT_BIT];
    assign install     = ack_fetch && pte_present && !flush_seen_reg && !flush;

    assign tbl_req    = (state_reg == FETCH);
    assign tbl_addr   = tbl_addr_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_ppn   = resp_ppn_reg;
    assign resp_fault = resp_fault_reg;
    assign hit_count  = hit_count_reg;

    mmu_tlb_cam #(
        .TAG_W(TAG_W),
        .PPN_W(PPN_W),
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_cam (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_tag(lookup_tag),
        .hit       (cam_hit),
        .hit_idx   (cam_hit_idx_unused),
        .hit_ppn   (cam_hit_ppn),
        .valid     (cam_valid),
        .wr_en     (install),
        .wr_idx    (victim_idx),
        .wr_tag    (tbl_addr_reg),
        .wr_ppn    (tbl_data[PTE_PPN_LSB +: PPN_W]),
        .flush_all (flush)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!cam_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        victim_idx = free_found ? free_idx : rr_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (is_sup || cam_hit) ? RESP : FETCH;
            FETCH:   if (tbl_ack) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_reg      <= 1'b0;
            tbl_addr_reg   <= '0;
            resp_ppn_reg   <= '0;
            resp_fault_reg <= 1'b0;
            flush_seen_reg <= 1'b0;
            rr_reg         <= '0;
            hit_count_reg  <= '0;
        end else begin
            alive_reg <= 1'b1;
            if (state_reg == IDLE && accept) begin
                if (is_sup) begin
                    resp_ppn_reg   <= {sup_base, req_vpn};
                    resp_fault_reg <= 1'b0;
                end else if (cam_hit) begin
                    resp_ppn_reg   <= cam_hit_ppn;
                    resp_fault_reg <= 1'b0;
                    if (hit_count_reg != 16'hFFFF) begin
                        hit_count_reg <= hit_count_reg + 16'd1;
                    end
                end else begin
                    tbl_addr_reg   <= lookup_tag;
                    flush_seen_reg <= 1'b0;
                end
            end
            if (state_reg == FETCH && flush) begin
                flush_seen_reg <= 1'b1;
            end
            if (ack_fetch) begin
                resp_ppn_reg   <= pte_present ? tbl_data[PTE_PPN_LSB +: PPN_W] : '0;
                resp_fault_reg <= !pte_present;
            end
            // The pointer only moves when it actually chose the victim.
            if (install && !free_found) begin
                rr_reg <= rr_reg + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: fills, hits, supervisor bypass, faults, eviction,
// flush during fetch, response back-pressure and reset during fetch.
module tb_mmu_tlb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_vpn = '0;
    logic [2:0]  req_fc = '0;
    logic [3:0]  req_task = '0;
    logic [3:0]  sup_base = '0;
    logic        flush = 1'b0;
    logic        tbl_req;
    logic [15:0] tbl_addr;
    logic        tbl_ack = 1'b0;
    logic [16:0] tbl_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_ppn;
    logic        resp_fault;
    logic [15:0] hit_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    mmu_tlb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vpn   (req_vpn),
        .req_fc    (req_fc),
        .req_task  (req_task),
        .sup_base  (sup_base),
        .flush     (flush),
        .tbl_req   (tbl_req),
        .tbl_addr  (tbl_addr),
        .tbl_ack   (tbl_ack),
        .tbl_data  (tbl_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_ppn  (resp_ppn),
        .resp_fault(resp_fault),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One full transaction; flush_at = fetch cycle (0..2, 3 = ack cycle) to pulse flush, -1 none.
    task automatic request(input string tag, input logic [2:0] fc, input logic [3:0] tk,
                           input logic [11:0] vpn, input bit exp_miss, input logic [16:0] pte,
                           input logic [15:0] exp_ppn, input bit exp_fault,
                           input int flush_at, input int hold);
        req_valid = 1'b1;
        req_fc    = fc;
        req_task  = tk;
        req_vpn   = vpn;
        check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_vpn   = 12'hFFF;
        req_task  = 4'hF;
        check({tag, ":tbl_req"}, 32'(tbl_req), 32'(exp_miss));
        if (exp_miss) begin
            check({tag, ":tbl_addr"}, 32'(tbl_addr), 32'({tk, vpn}));
            for (int i = 0; i < 3; i++) begin
                flush = (i == flush_at);
                tick();
                flush = 1'b0;
            end
            check({tag, ":tbl_hold"}, 32'({tbl_req, tbl_addr}), 32'({1'b1, tk, vpn}));
            tbl_ack  = 1'b1;
            tbl_data = pte;
            flush    = (flush_at == 3);
            tick();
            tbl_ack  = 1'b0;
            tbl_data = '0;
            flush    = 1'b0;
        end
        check({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ":resp_ppn"}, 32'(resp_ppn), 32'(exp_ppn));
        check({tag, ":resp_fault"}, 32'(resp_fault), 32'(exp_fault));
        check({tag, ":tbl_req_drop"}, 32'(tbl_req), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ":hold"}, 32'({resp_valid, req_ready, resp_fault, resp_ppn}),
                  32'({1'b1, 1'b0, exp_fault, exp_ppn}));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, ":done"}, 32'({resp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_outputs", 32'({req_ready, tbl_req, resp_valid, resp_fault}), 32'd0);
        check("rst_ppn_count", 32'({resp_ppn, hit_count}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);

        // Fill then hit for task 1 vpn 0x002
        request("fill_t1", 3'b001, 4'h1, 12'h002, 1'b1, 17'h11234, 16'h1234, 1'b0, -1, 0);
        request("hit_t1", 3'b001, 4'h1, 12'h002, 1'b0, 17'h0, 16'h1234, 1'b0, -1, 0);
        check("hit_count_1", 32'(hit_count), 32'd1);

        // Supervisor bypass
        sup_base = 4'h3;
        request("sup", 3'b101, 4'h1, 12'h0AB, 1'b0, 17'h0, 16'h30AB, 1'b0, -1, 0);
        check("sup_no_count", 32'(hit_count), 32'd1);

        // Not-present fault, and no install
        request("fault", 3'b001, 4'h1, 12'h010, 1'b1, 17'h00ABC, 16'h0000, 1'b1, -1, 0);
        request("fault_again", 3'b001, 4'h1, 12'h010, 1'b1, 17'h00ABC, 16'h0000, 1'b1, -1, 0);

        // Back-pressure on a hit
        request("hold_hit", 3'b001, 4'h1, 12'h002, 1'b0, 17'h0, 16'h1234, 1'b0, -1, 3);
        check("hit_count_2", 32'(hit_count), 32'd2);

        // Different task misses, original task entry survives
        request("t2_miss", 3'b001, 4'h2, 12'h002, 1'b1, 17'h15555, 16'h5555, 1'b0, -1, 0);
        request("t1_survive", 3'b001, 4'h1, 12'h002, 1'b0, 17'h0, 16'h1234, 1'b0, -1, 0);
        check("hit_count_3", 32'(hit_count), 32'd3);

        // Flush, then five fills into four entries
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            request("evict_fill", 3'b001, 4'h1, 12'(12'h100 + i), 1'b1,
                    17'(17'h10100 + i), 16'(16'h0100 + i), 1'b0, -1, 0);
        end
        for (int i = 1; i < 5; i++) begin
            request("evict_hit", 3'b001, 4'h1, 12'(12'h100 + i), 1'b0,
                    17'h0, 16'(16'h0100 + i), 1'b0, -1, 0);
        end
        check("hit_count_7", 32'(hit_count), 32'd7);
        request("evicted_refetch", 3'b001, 4'h1, 12'h100, 1'b1, 17'h10100, 16'h0100, 1'b0, -1, 0);

        // Flush mid-fetch: delivered, not installed
        request("flush_mid", 3'b001, 4'h1, 12'h200, 1'b1, 17'h17777, 16'h7777, 1'b0, 1, 0);
        request("flush_mid_miss", 3'b001, 4'h1, 12'h200, 1'b1, 17'h17777, 16'h7777, 1'b0, -1, 0);
        request("flush_mid_hit", 3'b001, 4'h1, 12'h200, 1'b0, 17'h0, 16'h7777, 1'b0, -1, 0);
        check("hit_count_8", 32'(hit_count), 32'd8);
        request("flush_ack", 3'b001, 4'h1, 12'h300, 1'b1, 17'h18888, 16'h8888, 1'b0, 3, 0);
        request("flush_ack_miss", 3'b001, 4'h1, 12'h300, 1'b1, 17'h18888, 16'h8888, 1'b0, -1, 0);

        // Reset during fetch
        req_valid = 1'b1;
        req_fc    = 3'b001;
        req_task  = 4'h1;
        req_vpn   = 12'h400;
        tick();
        req_valid = 1'b0;
        check("rstf_fetch", 32'(tbl_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstf_async_drop", 32'(tbl_req), 32'd0);
        tbl_ack  = 1'b1;
        tbl_data = 17'h19999;
        tick();
        check("rstf_in_reset", 32'({req_ready, tbl_req, resp_valid}), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("rstf_no_resp", 32'({resp_valid, tbl_req, req_ready}), 32'b001);
        check("rstf_count", 32'(hit_count), 32'd0);
        tbl_ack  = 1'b0;
        tbl_data = '0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
